// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
//   Shared definitions for the button debouncer block.
//   - state_t : 2-bit FSM state encoding. Adjacent states differ by one bit
//               (STABLE_LOW=00, WAIT_HIGH=01, STABLE_HIGH=11, WAIT_LOW=10).
//   - DEF_STABLE_CYCLES / DEF_CNT_WIDTH : default qualification parameters.
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'b00,
        ST_WAIT_HIGH   = 2'b01,
        ST_STABLE_HIGH = 2'b11,
        ST_WAIT_LOW    = 2'b10
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_WIDTH     = 4;

endpackage : button_debouncer_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level. Reusable for any
//   asynchronous input that needs to be brought into the i_clk domain.
//
// Ports:
//   i_clk   : destination clock, rising-edge active
//   i_rst_n : asynchronous active-low reset, clears both stages
//   i_d     : asynchronous input level
//   o_q     : synchronized level (two i_clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule : sync_2ff

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Conditions a raw, bouncy push-button/switch level for the D flip-flop data
//   path: synchronizes it to CLK, then accepts a new level only after it has
//   been seen for STABLE_CYCLES consecutive synchronized samples.
//
// Handshake: none. BTN_OUT is a level; RISE/FALL are single-cycle strobes on
//   the cycle BTN_OUT changes, never both high. BUSY is high while a candidate
//   level is being qualified. All outputs are registered.
//
// Ports:
//   CLK     : system clock, rising-edge active
//   RESET   : asynchronous active-low reset (0 = reset asserted)
//   BTN_IN  : raw asynchronous button/switch level
//   BTN_OUT : debounced level (drives downstream D)
//   RISE    : one-cycle strobe when BTN_OUT goes 0->1
//   FALL    : one-cycle strobe when BTN_OUT goes 1->0
//   BUSY    : high in WAIT_HIGH / WAIT_LOW
//
// Latency: a level stable before edge e0 appears on BTN_OUT at e0+STABLE_CYCLES+1.
// Legal STABLE_CYCLES range: 2 .. 2**CNT_WIDTH-1.
// -----------------------------------------------------------------------------
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    output logic BTN_OUT,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    // The first sample of a new level is taken in the STABLE state, so the
    // WAIT state only needs to see STABLE_CYCLES-1 more matching samples.
    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);

    logic                 w_sync;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_btn_out;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_busy;

    sync_2ff u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_d     (BTN_IN),
        .o_q     (w_sync)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= ST_STABLE_LOW;
            r_cnt     <= '0;
            r_btn_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Strobes default low so they last exactly one cycle.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_STABLE_LOW: begin
                    if (w_sync) begin
                        r_state <= ST_WAIT_HIGH;
                        r_cnt   <= LP_CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (w_sync) begin
                        if (r_cnt == LP_CNT_LAST) begin
                            r_state   <= ST_STABLE_HIGH;
                            r_cnt     <= '0;
                            r_btn_out <= 1'b1;
                            r_rise    <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + LP_CNT_ONE;
                        end
                    end else begin
                        // Reversal: drop the candidate, output untouched.
                        r_state <= ST_STABLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                ST_STABLE_HIGH: begin
                    if (!w_sync) begin
                        r_state <= ST_WAIT_LOW;
                        r_cnt   <= LP_CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                ST_WAIT_LOW: begin
                    if (!w_sync) begin
                        if (r_cnt == LP_CNT_LAST) begin
                            r_state   <= ST_STABLE_LOW;
                            r_cnt     <= '0;
                            r_btn_out <= 1'b0;
                            r_fall    <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + LP_CNT_ONE;
                        end
                    end else begin
                        r_state <= ST_STABLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_STABLE_LOW;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BTN_OUT = r_btn_out;
    assign RISE    = r_rise;
    assign FALL    = r_fall;
    assign BUSY    = r_busy;

endmodule : button_debouncer
